// File: rtl/pulse_receiver_pkg.sv
// Shared definitions for the pulse receiver: register map, CONFIG/TIMING field
// positions, bus write encodings, FSM states and the symbol encoder.
package pulse_receiver_pkg;

    localparam logic [5:0] ADDR_CONFIG    = 6'h00;
    localparam logic [5:0] ADDR_TIMING    = 6'h04;
    localparam logic [5:0] ADDR_STATUS    = 6'h08;
    localparam logic [5:0] ADDR_IRQ_CLR   = 6'h10;
    localparam logic [5:0] ADDR_DATA_BASE = 6'h20;

    localparam int CFG_ENABLE  = 0;
    localparam int CFG_INVERT  = 1;
    localparam int CFG_SEL_LSB = 2;
    localparam int CFG_IRQ_EN  = 5;
    localparam int CFG_IDLE    = 6;
    localparam int CFG_WIDTH   = 7;

    localparam int TIM_PRESC_LSB   = 0;
    localparam int TIM_LOW_LSB     = 4;
    localparam int TIM_HIGH_LSB    = 12;
    localparam int TIM_TIMEOUT_LSB = 20;
    localparam int TIM_WIDTH       = 28;

    localparam logic [1:0] WR_8    = 2'b00;
    localparam logic [1:0] WR_32   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_MEASURE = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    // A symbol is the level of the segment that just ended plus a long/short flag.
    function automatic logic [1:0] make_symbol(input logic level,
                                               input logic [7:0] duration,
                                               input logic [7:0] threshold);
        return {level, (duration > threshold)};
    endfunction

endpackage

// File: rtl/pulse_receiver_duration_counter.sv
// Prescaled tick generator feeding a saturating 8-bit segment duration counter.
module pulse_receiver_duration_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] prescaler,
    input  logic       presc_clr,
    input  logic       dur_clr,
    output logic [7:0] duration
);

    logic [15:0] presc_cnt_r;
    logic [15:0] mask_s;
    logic        tick_s;
    logic [7:0]  duration_r;

    assign mask_s   = (16'd1 << prescaler) - 16'd1;
    assign tick_s   = ((presc_cnt_r & mask_s) == mask_s);
    assign duration = duration_r;

    // Free-running prescaler counter, restarted when a measurement begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_r <= 16'd0;
        end else if (presc_clr) begin
            presc_cnt_r <= 16'd0;
        end else begin
            presc_cnt_r <= presc_cnt_r + 16'd1;
        end
    end

    // Duration restarts on every input edge and sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duration_r <= 8'd0;
        end else if (dur_clr) begin
            duration_r <= 8'd0;
        end else if (tick_s && (duration_r != 8'hFF)) begin
            duration_r <= duration_r + 8'd1;
        end else begin
            duration_r <= duration_r;
        end
    end

endmodule

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// TinyQV peripheral that classifies input pulse widths into 2-bit symbols
// and packs them into readable data words.
module tqvp_hx2003_pulse_receiver
    import pulse_receiver_pkg::*;
#(
    parameter int NUM_DATA_REG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam logic [6:0] LAST_INDEX = 7'(16 * NUM_DATA_REG - 1);

    logic [CFG_WIDTH-1:0] config_r;
    logic [TIM_WIDTH-1:0] timing_r;
    state_e               state_r;
    logic                 enable_q_r, rx_q_r, busy_r, done_r, overflow_r, irq_r;
    logic [6:0]           count_r;
    logic [31:0]          data_mem_r [NUM_DATA_REG];

    logic       enable_s, invert_s, irq_en_s, idle_level_s;
    logic [2:0] pin_sel_s;
    logic [3:0] prescaler_s;
    logic [7:0] low_thr_s, high_thr_s, timeout_val_s, duration_s;
    logic       rx_s, edge_s, at_idle_s, start_s, store_s, timeout_s, last_s;
    logic       irq_clr_s;
    logic [1:0] symbol_s;
    logic [31:0] data_word_s, rd_data_s;
    logic       unused_s;

    assign enable_s      = config_r[CFG_ENABLE];
    assign invert_s      = config_r[CFG_INVERT];
    assign pin_sel_s     = config_r[CFG_SEL_LSB +: 3];
    assign irq_en_s      = config_r[CFG_IRQ_EN];
    assign idle_level_s  = config_r[CFG_IDLE];
    assign prescaler_s   = timing_r[TIM_PRESC_LSB +: 4];
    assign low_thr_s     = timing_r[TIM_LOW_LSB +: 8];
    assign high_thr_s    = timing_r[TIM_HIGH_LSB +: 8];
    assign timeout_val_s = timing_r[TIM_TIMEOUT_LSB +: 8];

    assign rx_s      = ui_in[pin_sel_s] ^ invert_s;
    assign edge_s    = rx_s ^ rx_q_r;
    assign at_idle_s = (rx_q_r == idle_level_s);
    assign symbol_s  = make_symbol(rx_q_r, duration_s, rx_q_r ? high_thr_s : low_thr_s);

    assign start_s   = enable_s && (state_r == ST_WAIT) && edge_s && at_idle_s;
    assign store_s   = enable_s && (state_r == ST_MEASURE) && edge_s;
    assign last_s    = store_s && (count_r == LAST_INDEX);
    // An edge always wins over a timeout landing on the same cycle.
    assign timeout_s = enable_s && (state_r == ST_MEASURE) && !edge_s && at_idle_s &&
                       (timeout_val_s != 8'd0) && (duration_s == timeout_val_s);
    assign irq_clr_s = (data_write_n == WR_8) && (address == ADDR_IRQ_CLR) && data_in[0];

    assign unused_s = &{1'b0, data_read_n, data_in[31:28]};

    pulse_receiver_duration_counter u_duration (
        .clk       (clk),
        .rst_n     (rst_n),
        .prescaler (prescaler_s),
        .presc_clr (start_s),
        .dur_clr   (edge_s),
        .duration  (duration_s)
    );

    // CONFIG and TIMING take only full-word writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            config_r <= '0;
            timing_r <= '0;
        end else if (data_write_n == WR_32) begin
            if (address == ADDR_CONFIG) config_r <= data_in[CFG_WIDTH-1:0];
            if (address == ADDR_TIMING) timing_r <= data_in[TIM_WIDTH-1:0];
        end
    end

    // Input sampling and enable edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q_r     <= 1'b0;
            enable_q_r <= 1'b0;
        end else begin
            rx_q_r     <= rx_s;
            enable_q_r <= enable_s;
        end
    end

    // Reception FSM with symbol count and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            count_r    <= 7'd0;
        end else if (!enable_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!enable_q_r) begin
                        count_r    <= 7'd0;
                        overflow_r <= 1'b0;
                        done_r     <= 1'b0;
                        state_r    <= ST_WAIT;
                        busy_r     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (start_s) state_r <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (store_s) begin
                        count_r <= count_r + 7'd1;
                        if (last_s) begin
                            overflow_r <= 1'b1;
                            done_r     <= 1'b1;
                            state_r    <= ST_DONE;
                            busy_r     <= 1'b0;
                        end
                    end else if (timeout_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Symbol memory: symbol k sits in word k/16 at bit 2*(k%16).
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_DATA_REG; w++) begin
            if (store_s && (count_r[6:4] == 3'(w))) begin
                data_mem_r[w][{count_r[3:0], 1'b0} +: 2] <= symbol_s;
            end
        end
    end

    // Interrupt latch; a new completion beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else if ((timeout_s || last_s) && irq_en_s) begin
            irq_r <= 1'b1;
        end else if (irq_clr_s) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    // Data word lookup for the 0x20 window.
    always_comb begin
        data_word_s = 32'd0;
        for (int w = 0; w < NUM_DATA_REG; w++) begin
            data_word_s = data_word_s |
                ((address == (ADDR_DATA_BASE + 6'(4 * w))) ? data_mem_r[w] : 32'd0);
        end
    end

    // Read mux.
    always_comb begin
        rd_data_s = 32'd0;
        case (address)
            ADDR_CONFIG: rd_data_s = {25'd0, config_r};
            ADDR_TIMING: rd_data_s = {4'd0, timing_r};
            ADDR_STATUS: rd_data_s = {22'd0, busy_r, done_r, overflow_r, count_r};
            default:     rd_data_s = data_word_s;
        endcase
    end

    assign data_out       = rd_data_s;
    assign data_ready     = 1'b1;
    assign user_interrupt = irq_r;
    assign uo_out         = {4'd0, done_r, busy_r, rx_q_r, 1'b0};

endmodule

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// Directed bench for the pulse receiver; a second instance with one data word
// exercises symbol overflow alongside the default configuration.
module tb_tqvp_hx2003_pulse_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n, data_read_n;
    logic [7:0]  uo_out8, uo_out1;
    logic [31:0] data_out8, data_out1;
    logic        data_ready8, data_ready1, irq8, irq1;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    tqvp_hx2003_pulse_receiver #(.NUM_DATA_REG(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out8), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out8), .data_ready(data_ready8), .user_interrupt(irq8));

    tqvp_hx2003_pulse_receiver #(.NUM_DATA_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out1), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out1), .data_ready(data_ready1), .user_interrupt(irq1));

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; ui_in = 8'd0; address = 6'd0; data_write_n = 2'b11;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
        @(negedge clk);
        address = a; data_in = d; data_write_n = w;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic hold(input logic lvl, input int n);
        ui_in[0] = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic rd8(input logic [5:0] a, output logic [31:0] v);
        address = a; #1; v = data_out8;
    endtask

    task automatic rd1(input logic [5:0] a, output logic [31:0] v);
        address = a; #1; v = data_out1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (2) @(negedge clk);
        total++; if (uo_out8 !== 8'h00) begin $display("FAIL rst_uo got=%h exp=00", uo_out8); bad++; end
        total++; if (irq8 !== 1'b0) begin $display("FAIL rst_irq got=%b exp=0", irq8); bad++; end
        total++; if (data_ready8 !== 1'b1) begin $display("FAIL rst_ready got=%b exp=1", data_ready8); bad++; end
        rst_n = 1'b1;
        @(negedge clk);
        rd8(6'h00, v);
        total++; if (v !== 32'h0) begin $display("FAIL rst_config got=%h exp=0", v); bad++; end
        rd8(6'h04, v);
        total++; if (v !== 32'h0) begin $display("FAIL rst_timing got=%h exp=0", v); bad++; end
        rd8(6'h08, v);
        total++; if (v !== 32'h0) begin $display("FAIL rst_status got=%h exp=0", v); bad++; end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        wr(6'h04, 32'hFFFF_FFFF, 2'b10);
        rd8(6'h04, v);
        total++; if (v !== 32'h0FFF_FFFF) begin $display("FAIL timing_wr got=%h exp=0fffffff", v); bad++; end
        wr(6'h04, 32'h0, 2'b01);
        rd8(6'h04, v);
        total++; if (v !== 32'h0FFF_FFFF) begin $display("FAIL timing_16b got=%h exp=0fffffff", v); bad++; end
        wr(6'h00, 32'h0000_000E, 2'b10);
        @(negedge clk);
        total++; if (uo_out8 !== 8'h02) begin $display("FAIL pin_invert got=%h exp=02", uo_out8); bad++; end
        rd8(6'h00, v);
        total++; if (v !== 32'h0000_000E) begin $display("FAIL config_rd got=%h exp=0000000e", v); bad++; end
        ui_in[3] = 1'b1;
        @(negedge clk);
        total++; if (uo_out8 !== 8'h00) begin $display("FAIL pin3_high got=%h exp=00", uo_out8); bad++; end
        rd8(6'h0C, v);
        total++; if (v !== 32'h0) begin $display("FAIL unmapped got=%h exp=0", v); bad++; end
        ui_in = 8'd0;
        wr(6'h00, 32'h0, 2'b10);
    endtask

    task automatic test_pulses_irq();
        logic [31:0] v;
        apply_reset();
        wr(6'h04, 32'h00A0_4040, 2'b10);
        wr(6'h00, 32'h0000_0021, 2'b10);
        hold(1'b0, 2); hold(1'b1, 3);
        total++; if (uo_out8 !== 8'h06) begin $display("FAIL busy_mid got=%h exp=06", uo_out8); bad++; end
        hold(1'b0, 6); hold(1'b1, 8); hold(1'b0, 20);
        rd8(6'h08, v);
        total++; if (v !== 32'h0000_0103) begin $display("FAIL pulses_status got=%h exp=00000103", v); bad++; end
        rd8(6'h20, v);
        total++; if ((v & 32'h3F) !== 32'h36) begin $display("FAIL pulses_data got=%h exp=36", v & 32'h3F); bad++; end
        total++; if (irq8 !== 1'b1) begin $display("FAIL pulses_irq got=%b exp=1", irq8); bad++; end
        total++; if (uo_out8 !== 8'h08) begin $display("FAIL pulses_uo got=%h exp=08", uo_out8); bad++; end
        wr(6'h10, 32'h1, 2'b10);
        total++; if (irq8 !== 1'b1) begin $display("FAIL irq_clr32 got=%b exp=1", irq8); bad++; end
        wr(6'h10, 32'h1, 2'b00);
        total++; if (irq8 !== 1'b0) begin $display("FAIL irq_clr8 got=%b exp=0", irq8); bad++; end
    endtask

    task automatic test_no_irq();
        logic [31:0] v;
        apply_reset();
        wr(6'h04, 32'h00A0_4040, 2'b10);
        wr(6'h00, 32'h0000_0001, 2'b10);
        hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 6); hold(1'b1, 8); hold(1'b0, 20);
        rd8(6'h08, v);
        total++; if (v !== 32'h0000_0103) begin $display("FAIL noirq_status got=%h exp=00000103", v); bad++; end
        total++; if (irq8 !== 1'b0) begin $display("FAIL noirq_irq got=%b exp=0", irq8); bad++; end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        apply_reset();
        wr(6'h04, 32'h0000_4040, 2'b10);
        wr(6'h00, 32'h0000_0001, 2'b10);
        hold(1'b0, 2);
        for (int i = 0; i < 20; i++) begin
            hold(1'b1, 2); hold(1'b0, 2);
        end
        rd1(6'h08, v);
        total++; if (v !== 32'h0000_0190) begin $display("FAIL ovf_status got=%h exp=00000190", v); bad++; end
        rd1(6'h20, v);
        total++; if (v !== 32'h2222_2222) begin $display("FAIL ovf_data0 got=%h exp=22222222", v); bad++; end
        rd1(6'h24, v);
        total++; if (v !== 32'h0) begin $display("FAIL ovf_data1_absent got=%h exp=0", v); bad++; end
        total++; if (uo_out1 !== 8'h08) begin $display("FAIL ovf_uo got=%h exp=08", uo_out1); bad++; end
        rd8(6'h08, v);
        total++; if (v !== 32'h0000_0227) begin $display("FAIL run_status got=%h exp=00000227", v); bad++; end
        rd8(6'h24, v);
        total++; if (v !== 32'h2222_2222) begin $display("FAIL run_data1 got=%h exp=22222222", v); bad++; end
        rd8(6'h28, v);
        total++; if ((v & 32'h3FFF) !== 32'h2222) begin $display("FAIL run_data2 got=%h exp=2222", v & 32'h3FFF); bad++; end
        total++; if (uo_out8 !== 8'h04) begin $display("FAIL run_uo got=%h exp=04", uo_out8); bad++; end
    endtask

    task automatic test_timeout_edge();
        logic [31:0] v;
        apply_reset();
        wr(6'h04, 32'h00A0_4040, 2'b10);
        wr(6'h00, 32'h0000_0021, 2'b10);
        hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 11); hold(1'b1, 3);
        rd8(6'h08, v);
        total++; if (v !== 32'h0000_0202) begin $display("FAIL tedge_status got=%h exp=00000202", v); bad++; end
        rd8(6'h20, v);
        total++; if ((v & 32'hF) !== 32'h6) begin $display("FAIL tedge_data got=%h exp=6", v & 32'hF); bad++; end
        ui_in[0] = 1'b0;
        repeat (11) @(negedge clk);
        rd8(6'h08, v);
        total++; if (v !== 32'h0000_0203) begin $display("FAIL pre_timeout got=%h exp=00000203", v); bad++; end
        address = 6'h10; data_in = 32'h1; data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
        total++; if (irq8 !== 1'b1) begin $display("FAIL set_wins got=%b exp=1", irq8); bad++; end
        rd8(6'h08, v);
        total++; if (v !== 32'h0000_0103) begin $display("FAIL timeout_status got=%h exp=00000103", v); bad++; end
        rd8(6'h20, v);
        total++; if ((v & 32'h3F) !== 32'h26) begin $display("FAIL timeout_data got=%h exp=26", v & 32'h3F); bad++; end
    endtask

    task automatic test_disable_and_reset();
        logic [31:0] v;
        apply_reset();
        wr(6'h04, 32'h00A0_4040, 2'b10);
        wr(6'h00, 32'h0000_0021, 2'b10);
        hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 6);
        ui_in[0] = 1'b1;
        wr(6'h00, 32'h0000_0020, 2'b10);
        total++; if (uo_out8 !== 8'h06) begin $display("FAIL dis_same_cycle got=%h exp=06", uo_out8); bad++; end
        @(negedge clk);
        total++; if (uo_out8 !== 8'h02) begin $display("FAIL dis_next got=%h exp=02", uo_out8); bad++; end
        rd8(6'h08, v);
        total++; if (v !== 32'h0000_0002) begin $display("FAIL dis_status got=%h exp=00000002", v); bad++; end
        wr(6'h00, 32'h0000_0021, 2'b10);
        hold(1'b0, 2); hold(1'b1, 3);
        total++; if (uo_out8 !== 8'h06) begin $display("FAIL rearm got=%h exp=06", uo_out8); bad++; end
        address = 6'h08;
        #2 rst_n = 1'b0;
        #1;
        total++; if (uo_out8 !== 8'h00) begin $display("FAIL async_uo got=%h exp=00", uo_out8); bad++; end
        total++; if (irq8 !== 1'b0) begin $display("FAIL async_irq got=%b exp=0", irq8); bad++; end
        total++; if (data_out8 !== 32'h0) begin $display("FAIL async_status got=%h exp=0", data_out8); bad++; end
        ui_in = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd8(6'h00, v);
        total++; if (v !== 32'h0) begin $display("FAIL post_rst_config got=%h exp=0", v); bad++; end
    endtask

    initial begin
        rst_n = 1'b0; ui_in = 8'd0; address = 6'd0; data_in = 32'd0;
        data_write_n = 2'b11; data_read_n = 2'b11;
        test_reset();
        test_regs();
        test_pulses_irq();
        test_no_irq();
        test_overflow();
        test_timeout_edge();
        test_disable_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
